// File: rtl/off_on_timer.sv
// rtl/off_on_timer.sv - on-window timer driving a downstream on/off stage (IDLE/RUN/STOP/REL).
// Optional STOP watchdog enabled by defining OFF_ON_TIMEOUT_EN.
module off_on_timer #(
    parameter int DUR_W  = 16,
    parameter int TO_CYC = 255
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DUR_W-1:0] dur,
    input  logic             abort,
    input  logic             state_over,
    output logic [1:0]       i_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t           state;
    logic [DUR_W-1:0] cnt;

`ifdef OFF_ON_TIMEOUT_EN
    localparam int WD_W = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);
    logic [WD_W-1:0] wd;
    logic            err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            i_out <= 2'b00;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef OFF_ON_TIMEOUT_EN
            wd    <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef OFF_ON_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start && dur != '0) begin
                        state <= RUN;
                        cnt   <= dur;
                        i_out <= 2'b01;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    // Leaving at count 1 keeps the window exactly dur cycles and the counter off zero.
                    if (abort || cnt == DUR_W'(1)) begin
                        state <= STOP;
                        i_out <= 2'b11;
`ifdef OFF_ON_TIMEOUT_EN
                        wd    <= '0;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (!state_over) begin
                        state <= REL;
                        i_out <= 2'b00;
                        done  <= 1'b1;
                    end
`ifdef OFF_ON_TIMEOUT_EN
                    else if (wd == WD_W'(TO_CYC - 1)) begin
                        state <= REL;
                        i_out <= 2'b00;
                        done  <= 1'b1;
                        err_q <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                REL: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    i_out <= 2'b00;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_off_on_timer.sv
// tb/tb_off_on_timer.sv - scoreboard bench for off_on_timer with randomized windows.
module tb_off_on_timer;

`ifdef OFF_ON_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dur;
    logic        abort;
    logic        state_over;
    logic [1:0]  i_out;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk_sys = ~clk_sys;

    off_on_timer #(.DUR_W(16), .TO_CYC(TO)) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .start     (start),
        .dur       (dur),
        .abort     (abort),
        .state_over(state_over),
        .i_out     (i_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        int on;
        int stop;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_hold = 1'b1;
    int   on_c     = 0;
    int   stop_c   = 0;
    bit   prev_done = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: tallies the i_out run lengths of each window and scores them on done.
    always @(negedge clk_sys) begin
        if (mon_hold) begin
            on_c      = 0;
            stop_c    = 0;
            prev_done = 1'b0;
        end else begin
            check("i_out_never_10", int'(i_out == 2'b10), 0);
            if (prev_done) check("busy_low_after_done", int'(busy), 0);
            if (err && !done) check("err_without_done", int'(err), 0);
            if (i_out == 2'b01) on_c++;
            else if (i_out == 2'b11) stop_c++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", int'(done), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("on_cycles", on_c, e.on);
                    check("stop_cycles", stop_c, e.stop);
                    check("err_at_done", int'(err), int'(e.err));
                    check("busy_at_done", int'(busy), 1);
                end
                on_c   = 0;
                stop_c = 0;
            end
            prev_done = done;
        end
    end

    // One window: dur d, abort on the j-th edge after start (0 = none),
    // state_over sampled low on the n-th edge of STOP.
    task automatic run_txn(input int d, input int j, input int n);
        exp_t x;
        int   on;
        int   spur;
        on = (j > 0 && j < d) ? j : d;
        x.on   = on;
        x.stop = n;
        x.err  = 1'b0;
`ifdef OFF_ON_TIMEOUT_EN
        if (n > TO) begin
            x.stop = TO;
            x.err  = 1'b1;
        end
`endif
        exp_q.push_back(x);
        spur = $urandom_range(0, on);
        @(negedge clk_sys);
        start = 1'b1;
        dur   = 16'(d);
        abort = 1'b0;
        for (int t = 1; t <= on + n + 1; t++) begin
            @(negedge clk_sys);
            start = (t == spur);
            dur   = 16'($urandom);
            abort = (t == j);
            if (t <= on)         state_over = 1'($urandom);
            else if (t < on + n) state_over = 1'b1;
            else                 state_over = (t == on + n) ? 1'b0 : 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        dur        = '0;
        abort      = 1'b0;
        state_over = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("reset_i_out", int'(i_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_err", int'(err), 0);
        rst_n    = 1'b1;
        mon_hold = 1'b0;

        run_txn(5, 0, 2);
        run_txn(100, 20, 3);

        // dur==0 start must be ignored
        @(negedge clk_sys);
        start = 1'b1;
        dur   = '0;
        @(negedge clk_sys);
        start = 1'b0;
        check("zero_dur_busy", int'(busy), 0);
        check("zero_dur_i_out", int'(i_out), 0);
        repeat (2) @(negedge clk_sys);

        // reset three edges into a dur=50 window; concurrent start is lost
        mon_hold = 1'b1;
        @(negedge clk_sys);
        start = 1'b1;
        dur   = 16'd50;
        @(negedge clk_sys);
        start = 1'b0;
        @(negedge clk_sys);
        check("pre_reset_running", int'(i_out), 1);
        @(negedge clk_sys);
        rst_n = 1'b0;
        start = 1'b1;
        dur   = 16'd7;
        @(negedge clk_sys);
        check("mid_reset_i_out", int'(i_out), 0);
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_done", int'(done), 0);
        check("mid_reset_err", int'(err), 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk_sys);
        check("start_in_reset_lost", int'(busy), 0);
        mon_hold = 1'b0;
        run_txn(2, 0, 1);

        for (int i = 0; i < 40; i++) begin
            int d;
            int j;
            d = $urandom_range(1, 40);
            j = ($urandom_range(0, 2) == 0) ? $urandom_range(1, d + 2) : 0;
            run_txn(d, j, $urandom_range(1, 6));
        end
        run_txn(1, 0, 1);
        run_txn(3, 0, 1100);
        run_txn(65535, 0, 2);

        repeat (5) @(negedge clk_sys);
        check("all_windows_completed", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/off_on_timer.md
OFF_ON_TIMER -- requirements
Module: off_on_timer

Interface
REQ-001 SHALL have parameter DUR_W, default 16, width of the duration operand in clk_sys cycles.
REQ-002 SHALL have parameter TO_CYC, default 255, STOP-state watchdog limit in cycles; used only when OFF_ON_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk_sys  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to run one on-window.
REQ-006 SHALL have port dur  input  DUR_W  on-window length in cycles; sampled only when start is accepted.
REQ-007 SHALL have port abort  input  1  early termination of a running window.
REQ-008 SHALL have port state_over  input  1  downstream completion flag; low means the downstream stage has reached its stop state.
REQ-009 SHALL have port i_out  output  2  control to the downstream on/off stage: bit0 = enable/run, bit1 = stop request.
REQ-010 SHALL have port busy  output  1  high from the cycle after start is accepted until the cycle after done.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  one-cycle watchdog-expiry pulse.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, STOP and REL; all outputs SHALL be registered.
REQ-014 IDLE: i_out=00, busy=0; start=1 with dur!=0 at edge k SHALL latch dur, load counter=dur and enter RUN.
REQ-015 start with dur==0 SHALL be ignored: remain in IDLE, no done, no err.
REQ-016 RUN: i_out=01, busy=1; counter decrements each cycle; i_out=01 SHALL hold for exactly dur cycles, edges k+1..k+dur.
REQ-017 RUN to STOP SHALL occur when the counter reaches 1, so i_out=11 first appears at edge k+dur+1.
REQ-018 abort=1 sampled in RUN SHALL force STOP at the next edge regardless of counter; abort takes priority over counter expiry in the same cycle.
REQ-019 STOP: i_out=11; state_over sampled 0 SHALL move to REL at the next edge.
REQ-020 REL: i_out=00, done=1 for exactly one cycle, busy=0 from the following cycle; SHALL return to IDLE unconditionally.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the latched dur.
REQ-022 abort in IDLE, STOP or REL SHALL be ignored.
REQ-023 Counter width SHALL be DUR_W; the counter SHALL never wrap because RUN exits at 1 and dur==0 is rejected; maximum window = 2^DUR_W-1 cycles.
REQ-024 i_out SHALL never take the value 10.
REQ-025 Unused state encodings SHALL return to IDLE at the next edge with i_out=00.

Reset
REQ-026 rst_n=0 sampled at any edge SHALL force state IDLE, counter=0, i_out=00, busy=0, done=0, err=0, including mid-RUN or mid-STOP.
REQ-027 Operation SHALL resume only on a start sampled after rst_n has returned high; a start in the same cycle as rst_n=0 SHALL be lost.

Configuration
REQ-028 With macro OFF_ON_TIMEOUT_EN defined, a watchdog counter SHALL run in STOP; if state_over stays high for TO_CYC cycles, the FSM SHALL enter REL with err=1 and done=1 in the same cycle.
REQ-029 With OFF_ON_TIMEOUT_EN undefined, STOP SHALL wait indefinitely for state_over=0, err SHALL be tied 0, and no watchdog logic SHALL exist.

Verification
REQ-030 dur=5, start at edge 10, state_over drops at edge 17 -> i_out=01 at edges 11..15, i_out=11 at edges 16..17, done=1 at edge 18, busy low at edge 19.
REQ-031 dur=100, start, abort at edge +20 -> i_out=11 at edge +21, no further decrement, done after state_over=0.
REQ-032 dur=0 start, and start pulsed during RUN -> no state change and latched dur unchanged.
REQ-033 rst_n=0 at edge +3 of a dur=50 run -> all outputs 0 next edge; a new start with dur=2 then runs normally.
REQ-034 OFF_ON_TIMEOUT_EN defined, TO_CYC=8, state_over held 1 -> STOP lasts 8 cycles, then err=1 and done=1 together; without the macro, STOP persists for more than 1000 cycles and err stays 0.
REQ-035 dur=65535 -> exactly 65535 cycles of i_out=01; counter never wraps.
